// File: rtl/y86_dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : y86_dmem_stage
// Description : Multi-cycle data-memory stage for the Y86-64 SEQ processor.
//               Decodes the icode into a read, a write or a no-op access.
//               Performs it after WAIT_CYCLES wait states and signals
//               completion with a ready/start/done handshake. Out-of-range
//               and misaligned addresses are flagged through bad_mem.
// Ports       : clock, reset_n     - clock, synchronous active-low reset
//               start, ready       - request strobe / stage can accept
//               in_code            - Y86 icode
//               val_e, val_a, val_p- execute/fetch operands
//               done, bad_mem      - completion pulse / error status
//               val_m, mem_data    - read data / word at effective address
//               mem_add            - effective address of last accept
// Revision    : 1.0 - initial release
// ============================================================================
module y86_dmem_stage #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int INIT_WORDS  = 21
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        in_code,
  input  logic [63:0]       val_e,
  input  logic [63:0]       val_a,
  input  logic [DATA_W-1:0] val_p,
  output logic              ready,
  output logic              done,
  output logic              bad_mem,
  output logic [DATA_W-1:0] val_m,
  output logic [63:0]       mem_add,
  output logic [DATA_W-1:0] mem_data
);

  localparam int          c_aw        = $clog2(DEPTH);
  localparam logic [63:0] c_limit     = 64'(DEPTH) << 3;
  localparam logic [3:0]  c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          c_zero_wait = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_is_read;
  logic              r_is_write;
  logic              r_bad;
  logic [c_aw-1:0]   r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic              r_bad_mem;
  logic [DATA_W-1:0] r_val_m;
  logic [63:0]       r_mem_add;
  logic [DATA_W-1:0] r_mem_data;

  logic              w_accept;
  logic              w_dec_read;
  logic              w_dec_write;
  logic [63:0]       w_dec_addr;
  logic [DATA_W-1:0] w_dec_wdata;
  logic              w_dec_bad;
  logic [c_aw-1:0]   w_dec_idx;
  logic              w_op_read;
  logic              w_op_write;
  logic              w_op_bad;
  logic [c_aw-1:0]   w_op_idx;
  logic [DATA_W-1:0] w_op_wdata;
  logic              w_enter_done;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_words [DEPTH];

  assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = ready && start;

  // icode -> access type, effective address and store data
  always_comb begin
    w_dec_read  = (in_code == 4'd5) || (in_code == 4'd9) || (in_code == 4'd11);
    w_dec_write = (in_code == 4'd4) || (in_code == 4'd8) || (in_code == 4'd10);
    w_dec_addr  = ((in_code == 4'd9) || (in_code == 4'd11)) ? val_a : val_e;
    w_dec_wdata = (in_code == 4'd8) ? val_p : DATA_W'(val_a);
    // Range check uses all 64 address bits, so high garbage is caught too.
    w_dec_bad   = (w_dec_read || w_dec_write) &&
                  ((w_dec_addr >= c_limit) || (w_dec_addr[2:0] != 3'b000));
    w_dec_idx   = w_dec_addr[c_aw+2:3];
  end

  // With no wait states the access completes on its own accept edge, so the
  // live decode is used; otherwise the captured operation is used.
  always_comb begin
    w_op_read    = c_zero_wait ? w_dec_read  : r_is_read;
    w_op_write   = c_zero_wait ? w_dec_write : r_is_write;
    w_op_bad     = c_zero_wait ? w_dec_bad   : r_bad;
    w_op_idx     = c_zero_wait ? w_dec_idx   : r_idx;
    w_op_wdata   = c_zero_wait ? w_dec_wdata : r_wdata;
    w_enter_done = c_zero_wait ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0));
  end

  // Reset gates the write so a discarded access never reaches memory.
  assign w_we    = reset_n && w_enter_done && w_op_write && !w_op_bad;
  assign w_rdata = w_words[w_op_idx];

  // Word storage: each word carries its power-on value in its declaration;
  // reset does not touch the contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_W-1:0] r_word = (gi < INIT_WORDS) ? DATA_W'(gi) : '0;

    always_ff @(posedge clock) begin
      if (w_we && (w_op_idx == c_aw'(gi))) begin
        r_word <= w_op_wdata;
      end
    end

    assign w_words[gi] = r_word;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_is_read  <= 1'b0;
      r_is_write <= 1'b0;
      r_bad      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_bad_mem  <= 1'b0;
      r_val_m    <= '0;
      r_mem_add  <= 64'd0;
      r_mem_data <= '0;
    end else begin
      r_done <= w_enter_done;

      // The decoded access type stands in for the icode from here on.
      if (w_accept) begin
        r_is_read  <= w_dec_read;
        r_is_write <= w_dec_write;
        r_bad      <= w_dec_bad;
        r_idx      <= w_dec_idx;
        r_wdata    <= w_dec_wdata;
        r_mem_add  <= w_dec_addr;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (c_zero_wait) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_wait_load;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_done) begin
        if (w_op_bad) begin
          r_val_m    <= '0;
          r_mem_data <= '0;
          r_bad_mem  <= 1'b1;
        end else if (w_op_read) begin
          r_val_m    <= w_rdata;
          r_mem_data <= w_rdata;
          r_bad_mem  <= 1'b0;
        end else if (w_op_write) begin
          r_mem_data <= w_op_wdata;
          r_bad_mem  <= 1'b0;
        end else begin
          r_bad_mem  <= 1'b0;
        end
      end
    end
  end

  assign done     = r_done;
  assign bad_mem  = r_bad_mem;
  assign val_m    = r_val_m;
  assign mem_add  = r_mem_add;
  assign mem_data = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_y86_dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_dmem_stage
// Description : Directed self-checking bench for y86_dmem_stage. One
//               instance runs with two wait states and one with none.
//               Every check compares against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_dmem_stage;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        start0;
  logic [3:0]  in_code;
  logic [63:0] val_e;
  logic [63:0] val_a;
  logic [63:0] val_p;

  logic        ready,  done,  bad_mem;
  logic [63:0] val_m,  mem_add,  mem_data;
  logic        ready0, done0, bad_mem0;
  logic [63:0] val_m0, mem_add0, mem_data0;

  int n_total = 0;
  int n_bad   = 0;

  y86_dmem_stage #(.DATA_W(64), .DEPTH(1024), .WAIT_CYCLES(2), .INIT_WORDS(21)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_code(in_code),
    .val_e(val_e), .val_a(val_a), .val_p(val_p), .ready(ready), .done(done),
    .bad_mem(bad_mem), .val_m(val_m), .mem_add(mem_add), .mem_data(mem_data)
  );

  y86_dmem_stage #(.DATA_W(64), .DEPTH(1024), .WAIT_CYCLES(0), .INIT_WORDS(21)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .in_code(in_code),
    .val_e(val_e), .val_a(val_a), .val_p(val_p), .ready(ready0), .done(done0),
    .bad_mem(bad_mem0), .val_m(val_m0), .mem_add(mem_add0), .mem_data(mem_data0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one access on the two-wait-state instance and stops in the cycle
  // where done is high. lat counts cycles from the accept edge to done.
  task automatic run_op(input logic [3:0] c, input logic [63:0] e, a, p, output int lat);
    int guard = 0;
    while (ready !== 1'b1 && guard < 20) begin tick(); guard++; end
    in_code = c; val_e = e; val_a = a; val_p = p; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b want 0", done); end
    n_total++; if (bad_mem !== 1'b0) begin n_bad++; $display("FAIL rst_bad_mem: got %0b want 0", bad_mem); end
    n_total++; if (val_m !== 64'd0) begin n_bad++; $display("FAIL rst_val_m: got %h want 0", val_m); end
    n_total++; if (mem_add !== 64'd0) begin n_bad++; $display("FAIL rst_mem_add: got %h want 0", mem_add); end
    n_total++; if (mem_data !== 64'd0) begin n_bad++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    n_total++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", ready); end
    n_total++; if (ready0 !== 1'b1 || done0 !== 1'b0) begin n_bad++; $display("FAIL rst_dut0: got ready=%0b done=%0b want 1/0", ready0, done0); end
  endtask

  task automatic test_write_read();
    int lat;
    run_op(4'd4, 64'h40, 64'hDEAD, 64'd0, lat);
    n_total++; if (lat != 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_total++; if (mem_add !== 64'h40) begin n_bad++; $display("FAIL wr_mem_add: got %h want 40", mem_add); end
    n_total++; if (mem_data !== 64'hDEAD) begin n_bad++; $display("FAIL wr_mem_data: got %h want dead", mem_data); end
    n_total++; if (bad_mem !== 1'b0) begin n_bad++; $display("FAIL wr_bad_mem: got %0b want 0", bad_mem); end
    n_total++; if (val_m !== 64'd0) begin n_bad++; $display("FAIL wr_val_m_kept: got %h want 0", val_m); end
    tick();
    n_total++; if (done !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL done_pulse: got done=%0b ready=%0b want 0/1", done, ready); end
    run_op(4'd5, 64'h40, 64'd0, 64'd0, lat);
    n_total++; if (lat != 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_total++; if (val_m !== 64'hDEAD) begin n_bad++; $display("FAIL rd_val_m: got %h want dead", val_m); end
    n_total++; if (mem_data !== 64'hDEAD) begin n_bad++; $display("FAIL rd_mem_data: got %h want dead", mem_data); end
  endtask

  task automatic test_power_on();
    int lat;
    run_op(4'd5, 64'h28, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'd5) begin n_bad++; $display("FAIL init_w5: got %h want 5", val_m); end
    run_op(4'd5, 64'hA0, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'd20) begin n_bad++; $display("FAIL init_w20: got %h want 14", val_m); end
    run_op(4'd5, 64'hA8, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'd0) begin n_bad++; $display("FAIL init_w21: got %h want 0", val_m); end
    run_op(4'd5, 64'h100, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'd0 || mem_add !== 64'h100) begin n_bad++; $display("FAIL init_w32: got val_m=%h mem_add=%h want 0/100", val_m, mem_add); end
  endtask

  task automatic test_call_ret();
    int lat;
    run_op(4'd8, 64'h1F8, 64'h555, 64'h123, lat);
    n_total++; if (mem_data !== 64'h123 || bad_mem !== 1'b0) begin n_bad++; $display("FAIL call_store: got mem_data=%h bad=%0b want 123/0", mem_data, bad_mem); end
    run_op(4'd9, 64'h777, 64'h1F8, 64'd0, lat);
    n_total++; if (val_m !== 64'h123) begin n_bad++; $display("FAIL ret_val_m: got %h want 123", val_m); end
    n_total++; if (mem_add !== 64'h1F8) begin n_bad++; $display("FAIL ret_mem_add: got %h want 1f8", mem_add); end
    run_op(4'd11, 64'h999, 64'h28, 64'd0, lat);
    n_total++; if (val_m !== 64'd5 || mem_add !== 64'h28) begin n_bad++; $display("FAIL popq: got val_m=%h mem_add=%h want 5/28", val_m, mem_add); end
  endtask

  task automatic test_bad_access();
    int lat;
    run_op(4'd5, 64'h2000, 64'd0, 64'd0, lat);
    n_total++; if (bad_mem !== 1'b1) begin n_bad++; $display("FAIL oor_bad_mem: got %0b want 1", bad_mem); end
    n_total++; if (val_m !== 64'd0 || mem_data !== 64'd0) begin n_bad++; $display("FAIL oor_data: got val_m=%h mem_data=%h want 0/0", val_m, mem_data); end
    tick(); tick();
    n_total++; if (bad_mem !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL bad_hold: got bad=%0b done=%0b want 1/0", bad_mem, done); end
    run_op(4'd10, 64'h41, 64'hBEEF, 64'd0, lat);
    n_total++; if (bad_mem !== 1'b1 || mem_add !== 64'h41) begin n_bad++; $display("FAIL misalign: got bad=%0b mem_add=%h want 1/41", bad_mem, mem_add); end
    run_op(4'd5, 64'h40, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'hDEAD || bad_mem !== 1'b0) begin n_bad++; $display("FAIL misalign_nowrite: got val_m=%h bad=%0b want dead/0", val_m, bad_mem); end
    run_op(4'd5, 64'h8000_0000_0000_0040, 64'd0, 64'd0, lat);
    n_total++; if (bad_mem !== 1'b1) begin n_bad++; $display("FAIL high_addr: got %0b want 1", bad_mem); end
    run_op(4'd4, 64'h1FF8, 64'hCAFE, 64'd0, lat);
    n_total++; if (bad_mem !== 1'b0) begin n_bad++; $display("FAIL last_word_wr: got bad=%0b want 0", bad_mem); end
    run_op(4'd5, 64'h1FF8, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'hCAFE) begin n_bad++; $display("FAIL last_word_rd: got %h want cafe", val_m); end
    run_op(4'd0, 64'h2000, 64'h1, 64'd0, lat);
    n_total++; if (bad_mem !== 1'b0 || mem_add !== 64'h2000) begin n_bad++; $display("FAIL nop_status: got bad=%0b mem_add=%h want 0/2000", bad_mem, mem_add); end
    n_total++; if (val_m !== 64'hCAFE || mem_data !== 64'hCAFE) begin n_bad++; $display("FAIL nop_hold: got val_m=%h mem_data=%h want cafe/cafe", val_m, mem_data); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    run_op(4'd4, 64'h60, 64'h77, 64'd0, lat);
    n_total++; if (ready !== 1'b1 || done !== 1'b1) begin n_bad++; $display("FAIL done_ready: got ready=%0b done=%0b want 1/1", ready, done); end
    run_op(4'd5, 64'h60, 64'd0, 64'd0, lat);
    n_total++; if (lat != 3) begin n_bad++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    n_total++; if (val_m !== 64'h77) begin n_bad++; $display("FAIL b2b_raw: got %h want 77", val_m); end
    tick();
    in_code = 4'd4; val_e = 64'h48; val_a = 64'h11; start = 1'b1;
    tick();
    val_e = 64'h50; val_a = 64'h22;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) n++;
      tick();
    end
    n_total++; if (n != 1) begin n_bad++; $display("FAIL wait_start_ignored: got %0d dones want 1", n); end
    run_op(4'd5, 64'h48, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'h11) begin n_bad++; $display("FAIL first_req_kept: got %h want 11", val_m); end
    run_op(4'd5, 64'h50, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'd10) begin n_bad++; $display("FAIL dropped_req: got %h want a", val_m); end
    tick();
  endtask

  task automatic test_zero_wait();
    start0 = 1'b1; in_code = 4'd4; val_e = 64'h100; val_a = 64'hA1;
    tick();
    n_total++; if (done0 !== 1'b1 || mem_data0 !== 64'hA1 || mem_add0 !== 64'h100) begin n_bad++; $display("FAIL zw_wr1: got done=%0b data=%h add=%h want 1/a1/100", done0, mem_data0, mem_add0); end
    n_total++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL zw_ready: got %0b want 1", ready0); end
    val_e = 64'h108; val_a = 64'hA2;
    tick();
    n_total++; if (done0 !== 1'b1 || mem_data0 !== 64'hA2) begin n_bad++; $display("FAIL zw_wr2: got done=%0b data=%h want 1/a2", done0, mem_data0); end
    in_code = 4'd5; val_e = 64'h100;
    tick();
    n_total++; if (done0 !== 1'b1 || val_m0 !== 64'hA1) begin n_bad++; $display("FAIL zw_rd: got done=%0b val_m=%h want 1/a1", done0, val_m0); end
    in_code = 4'd4; val_e = 64'h110; val_a = 64'hB3;
    tick();
    in_code = 4'd5;
    tick();
    n_total++; if (val_m0 !== 64'hB3) begin n_bad++; $display("FAIL zw_raw: got %h want b3", val_m0); end
    start0 = 1'b0;
    tick();
    n_total++; if (done0 !== 1'b0 || ready0 !== 1'b1) begin n_bad++; $display("FAIL zw_idle: got done=%0b ready=%0b want 0/1", done0, ready0); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    in_code = 4'd10; val_e = 64'h80; val_a = 64'h999; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got ready=%0b want 0", ready); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_total++; if (done !== 1'b0 || bad_mem !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL mid_ctrl: got done=%0b bad=%0b ready=%0b want 0/0/1", done, bad_mem, ready); end
    n_total++; if (val_m !== 64'd0 || mem_add !== 64'd0 || mem_data !== 64'd0) begin n_bad++; $display("FAIL mid_data: got val_m=%h add=%h data=%h want 0/0/0", val_m, mem_add, mem_data); end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) n++;
      tick();
    end
    n_total++; if (n != 0) begin n_bad++; $display("FAIL mid_no_done: got %0d dones want 0", n); end
    run_op(4'd5, 64'h80, 64'd0, 64'd0, lat);
    n_total++; if (val_m !== 64'd16) begin n_bad++; $display("FAIL mid_no_write: got %h want 10", val_m); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start0 = 1'b0;
    in_code = 4'd0; val_e = 64'd0; val_a = 64'd0; val_p = 64'd0;
    test_reset();
    test_write_read();
    test_power_on();
    test_call_ret();
    test_bad_access();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
